// File: rtl/unit_deteccion_riesgos.sv
// ID-stage hazard/stall controller: load-use stall, taken-branch flush, HALT drain/freeze.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module unit_deteccion_riesgos #(
    parameter int BITS_REGS    = 5,
    parameter int STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_IDEX_mem_read,
    input  logic [BITS_REGS-1:0] i_IDEX_rt,
    input  logic [BITS_REGS-1:0] i_IFID_rs,
    input  logic [BITS_REGS-1:0] i_IFID_rt,
    input  logic                 i_branch_taken,
    input  logic                 i_halt,
    input  logic                 i_resume,
    output logic                 o_pc_write,
    output logic                 o_IFID_write,
    output logic                 o_IFID_flush,
    output logic                 o_ctrl_bubble,
`ifdef HAZARD_STATS_EN
    output logic [15:0]          o_stall_count,
    output logic [15:0]          o_flush_count,
`endif
    output logic                 o_halted
);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       halted_q, halted_d;
    logic       hz;
    logic       pc_write, ifid_write, ifid_flush, ctrl_bubble, stall_bubble;

    assign hz = i_IDEX_mem_read && (i_IDEX_rt != '0) &&
                ((i_IDEX_rt == i_IFID_rs) || (i_IDEX_rt == i_IFID_rt));

    // The hazard cycle in RUN is the first bubble, so STALL leaves once cnt
    // decrements to 0; DRAIN holds for the full count before freezing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        halted_d     = halted_q;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        ctrl_bubble  = 1'b1;
        stall_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (hz) begin
                    stall_bubble = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end else if (i_halt) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = i_branch_taken;
                    ctrl_bubble = 1'b0;
                end
            end
            STALL: begin
                stall_bubble = 1'b1;
                cnt_d = (cnt_q != '0) ? cnt_q - 3'd1 : '0;
                if (cnt_q <= 3'd1) state_d = RUN;
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HALTED: begin
                if (i_resume) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
        if (i_reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b0;
            ctrl_bubble  = 1'b1;
            stall_bubble = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign o_pc_write    = pc_write;
    assign o_IFID_write  = ifid_write;
    assign o_IFID_flush  = ifid_flush;
    assign o_ctrl_bubble = ctrl_bubble;
    assign o_halted      = halted_q && !i_reset;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_bubble && stall_count_q != '1) stall_count_d = stall_count_q + 16'd1;
        if (ifid_flush && flush_count_q != '1)   flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
    assign o_flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_unit_deteccion_riesgos.sv
// Bench for unit_deteccion_riesgos: two instances (STALL_CYCLES 1 and 3) against a cycle-level model.
// Stats ports are connected and checked when HAZARD_STATS_EN is defined.
module tb_unit_deteccion_riesgos;

    logic       clk = 1'b0;
    logic       rst, mr, br, ht, rsm;
    logic [4:0] xrt, rs, rt;
    logic       pc_a, wr_a, fl_a, bb_a, hl_a;
    logic       pc_b, wr_b, fl_b, bb_b, hl_b;
    logic [4:0] out_a, out_b;
    int         checks = 0;
    int         errors = 0;

    // Model state per instance: remaining stall bubbles, remaining drain cycles, frozen flag
    int         m_stall[2];
    int         m_drain[2];
    bit         m_halt[2];
    int         m_sc[2];
    int         m_fc[2];
    int         sc_par[2];

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    logic [15:0] stc_a, flc_a, stc_b, flc_b;
`endif

    unit_deteccion_riesgos #(.BITS_REGS(5), .STALL_CYCLES(1), .DRAIN_CYCLES(3)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_IDEX_mem_read(mr), .i_IDEX_rt(xrt),
        .i_IFID_rs(rs), .i_IFID_rt(rt), .i_branch_taken(br), .i_halt(ht), .i_resume(rsm),
        .o_pc_write(pc_a), .o_IFID_write(wr_a), .o_IFID_flush(fl_a), .o_ctrl_bubble(bb_a),
`ifdef HAZARD_STATS_EN
        .o_stall_count(stc_a), .o_flush_count(flc_a),
`endif
        .o_halted(hl_a));

    unit_deteccion_riesgos #(.BITS_REGS(5), .STALL_CYCLES(3), .DRAIN_CYCLES(3)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_IDEX_mem_read(mr), .i_IDEX_rt(xrt),
        .i_IFID_rs(rs), .i_IFID_rt(rt), .i_branch_taken(br), .i_halt(ht), .i_resume(rsm),
        .o_pc_write(pc_b), .o_IFID_write(wr_b), .o_IFID_flush(fl_b), .o_ctrl_bubble(bb_b),
`ifdef HAZARD_STATS_EN
        .o_stall_count(stc_b), .o_flush_count(flc_b),
`endif
        .o_halted(hl_b));

    assign out_a = {pc_a, wr_a, fl_a, bb_a, hl_a};
    assign out_b = {pc_b, wr_b, fl_b, bb_b, hl_b};

    typedef struct {
        logic       rst, mr;
        logic [4:0] xrt, rs, rt;
        logic       br, ht, rsm;
        logic [4:0] exp_a;
    } vec_t;
    vec_t tbl[19];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model(input int k, output logic [4:0] e);
        bit hz;
        hz = mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
        if (rst) begin
            e = 5'b00010;
            m_stall[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else if (m_halt[k]) begin
            e = 5'b00011;
            if (rsm) m_halt[k] = 0;
        end else if (m_drain[k] > 0) begin
            e = 5'b00010;
            m_drain[k]--;
            if (m_drain[k] == 0) m_halt[k] = 1;
        end else if (m_stall[k] > 0) begin
            e = 5'b00010;
            m_stall[k]--;
            if (m_sc[k] < 65535) m_sc[k]++;
        end else if (hz) begin
            e = 5'b00010;
            m_stall[k] = sc_par[k] - 1;
            if (m_sc[k] < 65535) m_sc[k]++;
        end else if (ht) begin
            e = 5'b00010;
            m_drain[k] = 3;
        end else if (br) begin
            e = 5'b11100;
            if (m_fc[k] < 65535) m_fc[k]++;
        end else begin
            e = 5'b11000;
        end
    endtask

    // Applies inputs, lets them settle, compares both instances to the model (pre-edge)
    task automatic drive(input logic r, input logic m, input logic [4:0] x, input logic [4:0] s,
                         input logic [4:0] t, input logic b, input logic h, input logic q);
        logic [4:0] ea, eb;
        rst = r; mr = m; xrt = x; rs = s; rt = t; br = b; ht = h; rsm = q;
        #2;
`ifdef HAZARD_STATS_EN
        check("stall_cnt_a", stc_a, 16'(m_sc[0]));
        check("flush_cnt_a", flc_a, 16'(m_fc[0]));
        check("stall_cnt_b", stc_b, 16'(m_sc[1]));
        check("flush_cnt_b", flc_b, 16'(m_fc[1]));
`endif
        model(0, ea);
        model(1, eb);
        check("model_a", 16'(out_a), 16'(ea));
        check("model_b", 16'(out_b), 16'(eb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sc_par[0] = 1; sc_par[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_drain[k] = 0; m_halt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        //            rst mr  xrt   rs    rt    br  ht  rsm  {pc,wr,fl,bb,hl}
        tbl[0]  = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b00010};
        tbl[1]  = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b11000};
        tbl[2]  = '{1'b0,1'b1,5'd5,5'd5,5'd0,1'b0,1'b0,1'b0,5'b00010};
        tbl[3]  = '{1'b0,1'b0,5'd5,5'd5,5'd0,1'b0,1'b0,1'b0,5'b11000};
        tbl[4]  = '{1'b0,1'b1,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b11000};
        tbl[5]  = '{1'b0,1'b1,5'd7,5'd1,5'd7,1'b1,1'b0,1'b0,5'b00010};
        tbl[6]  = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,5'b11100};
        tbl[7]  = '{1'b0,1'b1,5'd3,5'd4,5'd2,1'b0,1'b0,1'b0,5'b11000};
        tbl[8]  = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,5'b00010};
        tbl[9]  = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,5'b00010};
        tbl[10] = '{1'b0,1'b1,5'd5,5'd5,5'd5,1'b0,1'b0,1'b0,5'b00010};
        tbl[11] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,5'b00010};
        tbl[12] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b00011};
        tbl[13] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,5'b00011};
        tbl[14] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b11000};
        tbl[15] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b1,1'b0,5'b00010};
        tbl[16] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b00010};
        tbl[17] = '{1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b00010};
        tbl[18] = '{1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,5'b11000};

        rst = 1'b1; mr = 1'b0; xrt = '0; rs = '0; rt = '0; br = 1'b0; ht = 1'b0; rsm = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].mr, tbl[i].xrt, tbl[i].rs, tbl[i].rt,
                  tbl[i].br, tbl[i].ht, tbl[i].rsm);
            check($sformatf("tbl%0d_a", i), 16'(out_a), 16'(tbl[i].exp_a));
            tick();
        end

        // STALL_CYCLES=3: one hazard yields exactly three bubble cycles
        drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
        check("st3_c0", 16'(out_b), 16'(5'b00010));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("st3_c1", 16'(out_b), 16'(5'b00010));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("st3_c2", 16'(out_b), 16'(5'b00010));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("st3_c3", 16'(out_b), 16'(5'b11000));
        tick();

        // hazard beats branch; branch re-presented afterwards flushes
        drive(0, 1, 5'd4, 5'd0, 5'd4, 1, 0, 0);
        check("hzbr_a0", 16'(out_a), 16'(5'b00010));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        check("hzbr_a1", 16'(out_a), 16'(5'b11100));
        check("hzbr_b1", 16'(out_b), 16'(5'b00010));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("hzbr_a2", 16'(out_a), 16'(5'b11000));
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();

        // halt then reset in the middle of drain
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("drain_b", 16'(out_b), 16'(5'b00010));
        tick();
        drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("rst_drain_a", 16'(out_a), 16'(5'b11000));
        check("rst_drain_b", 16'(out_b), 16'(5'b11000));
        tick();

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0));
            tick();
        end

`ifdef HAZARD_STATS_EN
        drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        tick();
        for (int n = 0; n < 65540; n++) begin
            drive(0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("stall_sat_a", stc_a, 16'hFFFF);
        check("stall_sat_b", stc_b, 16'hFFFF);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
